ahb_lite_regbank_slave: RTL and testbench

//  Parametrised AHB-Lite slave register bank; successor to the fixed UART register slave.

---
 rtl/ahb_pkg.sv | 43 ++++
 rtl/ahb_byte_lane_gen.sv | 36 +++
 rtl/ahb_lite_regbank_slave.sv | 179 +++++++++++++++++
 tb/tb_ahb_lite_regbank_slave.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and helpers for the register-bank slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slv_state_e;

  // Byte-lane mask for a transfer of 2**size bytes starting at byte offset lo,
  // for buses up to 64 bits wide. Sizes wider than a doubleword give no lanes.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] lo);
    logic [7:0] base;
    case (size)
      HSIZE_BYTE:  base = 8'h01;
      HSIZE_HALF:  base = 8'h03;
      HSIZE_WORD:  base = 8'h0F;
      HSIZE_DWORD: base = 8'hFF;
      default:     base = 8'h00;
    endcase
    return base << lo;
  endfunction

endpackage

// File: rtl/ahb_byte_lane_gen.sv
// Maps (HSIZE, low address bits) to a byte-lane strobe and a misalignment flag.
module ahb_byte_lane_gen
  import ahb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int BL     = $clog2(NB)
) (
  input  logic [2:0]    hsize_i,
  input  logic [BL-1:0] addr_lo_i,
  output logic [NB-1:0] strb_o,
  output logic          misalign_o
);

  logic [2:0] lo3;
  logic [7:0] mask8;
  logic       unused_mask;

  assign lo3         = 3'(addr_lo_i);
  assign mask8       = lane_mask(hsize_i, lo3);
  assign strb_o      = mask8[NB-1:0];
  assign unused_mask = ^mask8;

  // A transfer is misaligned when the offset is not a multiple of its size.
  always_comb begin
    misalign_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE:  misalign_o = 1'b0;
      HSIZE_HALF:  misalign_o = lo3[0];
      HSIZE_WORD:  misalign_o = |lo3[1:0];
      HSIZE_DWORD: misalign_o = |lo3;
      default:     misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_lite_regbank_slave.sv
// Parametrised AHB-Lite register bank: byte-lane writes, optional wait states,
// read-only registers sourced from reg_i, and a two-cycle ERROR response.
//
// Handshake: an address phase is taken when HSEL & HREADY & HTRANS is NONSEQ/SEQ
// and the slave is in a ready state (IDLE, DATA or ERR2). Its data phase ends on
// the first cycle with HREADYOUT=1; HRESP qualifies that cycle, and HRDATA is
// only meaningful (non-zero) in the DATA cycle of a read.
module ahb_lite_regbank_slave
  import ahb_pkg::*;
#(
  parameter int                   DATA_W      = 32,
  parameter int                   NUM_REGS    = 8,
  parameter int                   ADDR_W      = 12,
  parameter int                   WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL   = '0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         HSEL,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic                         HREADY,
  input  logic [DATA_W-1:0]            HWDATA,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADYOUT,
  output logic                         HRESP,
  output logic [NUM_REGS*DATA_W-1:0]   reg_o,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_i,
  output logic [NUM_REGS-1:0]          wr_pulse_o,
  output logic [NUM_REGS-1:0]          rd_pulse_o,
  output logic [2:0]                   dbg_state_o
);

  localparam int NB      = DATA_W / 8;
  localparam int BL      = $clog2(NB);
  localparam int IDX_W   = ADDR_W - BL;
  localparam int RIDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W:0]        NUM_REGS_W = (IDX_W+1)'(NUM_REGS);
  localparam logic [2:0]            BL3        = 3'(BL);
  localparam logic [3:0]            WS_LOAD    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [NUM_REGS-1:0]   ONE        = 1;

  slv_state_e          state_q;
  logic [3:0]          cnt_q;
  logic                hreadyout_q;
  logic                hresp_q;
  logic [RIDX_W-1:0]   idx_q;
  logic [NB-1:0]       strb_q;
  logic                write_q;
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   ro_src [NUM_REGS];
  logic [DATA_W-1:0]   wr_word_d;

  // Address-phase decode
  logic [IDX_W-1:0]  a_idx;
  logic [RIDX_W-1:0] a_ridx;
  logic [NB-1:0]     a_strb;
  logic              a_misalign;
  logic              a_in_range;
  logic              a_err;
  logic              ready_state;
  logic              accept;
  logic              wr_en;
  logic              rd_active;

  assign a_idx       = HADDR[ADDR_W-1:BL];
  assign a_ridx      = a_idx[RIDX_W-1:0];
  assign a_in_range  = ({1'b0, a_idx} < NUM_REGS_W);
  assign a_err       = !a_in_range || (HSIZE > BL3) || a_misalign ||
                       (HWRITE && a_in_range && RO_MASK[a_ridx]);
  assign ready_state = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept      = HSEL && HREADY && ready_state &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  ahb_byte_lane_gen #(.DATA_W(DATA_W)) u_lane_gen (
    .hsize_i    (HSIZE),
    .addr_lo_i  (HADDR[BL-1:0]),
    .strb_o     (a_strb),
    .misalign_o (a_misalign)
  );

  // Transfer sequencer: address accept, wait-state countdown, two-cycle error.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      idx_q       <= '0;
      strb_q      <= '0;
      write_q     <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_DATA;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          // IDLE, DATA and ERR2 all present HREADYOUT=1, so a new address may land here.
          if (accept) begin
            if (a_err) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
              write_q     <= 1'b0;
            end else begin
              idx_q   <= a_ridx;
              strb_q  <= a_strb;
              write_q <= HWRITE;
              hresp_q <= HRESP_OKAY;
              if (WAIT_STATES > 0) begin
                state_q     <= S_WAIT;
                cnt_q       <= WS_LOAD;
                hreadyout_q <= 1'b0;
              end else begin
                state_q     <= S_DATA;
                hreadyout_q <= 1'b1;
              end
            end
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign wr_en     = (state_q == S_DATA) && write_q;
  assign rd_active = (state_q == S_DATA) && !write_q;

  // Merge the selected byte lanes of HWDATA into the addressed register.
  always_comb begin
    wr_word_d = regs_q[idx_q];
    for (int b = 0; b < NB; b++) begin
      if (strb_q[b]) wr_word_d[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  // Register storage and write pulse; commits at the end of the write DATA cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      wr_pulse_q <= '0;
    end else begin
      if (wr_en) regs_q[idx_q] <= wr_word_d;
      wr_pulse_q <= wr_en ? (ONE << idx_q) : '0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign ro_src[i]                  = reg_i[i*DATA_W +: DATA_W];
    assign reg_o[i*DATA_W +: DATA_W]  = regs_q[i];
  end

  // Read data is driven only during a read DATA cycle; a write committed on the
  // previous edge is already in regs_q, so back-to-back reads see the new value.
  assign HRDATA      = rd_active ? (RO_MASK[idx_q] ? ro_src[idx_q] : regs_q[idx_q]) : '0;
  assign rd_pulse_o  = rd_active ? (ONE << idx_q) : '0;
  assign wr_pulse_o  = wr_pulse_q;
  assign HREADYOUT   = hreadyout_q;
  assign HRESP       = hresp_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_lite_regbank_slave.sv
// Directed bench for the AHB-Lite register bank: one zero-wait instance with a
// read-only register, one three-wait-state instance with a non-zero reset value.
module tb_ahb_lite_regbank_slave;

  localparam int W  = 32;
  localparam int NR = 8;

  // ---------------- clock / reset ----------------
  logic hclk;
  logic hresetn;
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // ---------------- shared bus drive ----------------
  logic          hsel_a, hsel_b;
  logic [11:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [W-1:0]  hwdata;
  logic          mux_ready;

  logic [W-1:0]     hrdata_a, hrdata_b;
  logic             hreadyout_a, hreadyout_b;
  logic             hresp_a, hresp_b;
  logic             hready_a, hready_b;
  logic [NR*W-1:0]  reg_o_a, reg_o_b, reg_i_a, reg_i_b;
  logic [NR-1:0]    wr_pulse_a, wr_pulse_b, rd_pulse_a, rd_pulse_b;
  logic [2:0]       dbg_a, dbg_b;

  assign hready_a = hreadyout_a & mux_ready;
  assign hready_b = hreadyout_b & mux_ready;

  ahb_lite_regbank_slave #(
    .DATA_W(W), .NUM_REGS(NR), .ADDR_W(12), .WAIT_STATES(0),
    .RO_MASK(8'h04), .RESET_VAL(32'h0000_0000)
  ) u_a (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready_a), .HWDATA(hwdata),
    .HRDATA(hrdata_a), .HREADYOUT(hreadyout_a), .HRESP(hresp_a),
    .reg_o(reg_o_a), .reg_i(reg_i_a), .wr_pulse_o(wr_pulse_a), .rd_pulse_o(rd_pulse_a),
    .dbg_state_o(dbg_a)
  );

  ahb_lite_regbank_slave #(
    .DATA_W(W), .NUM_REGS(NR), .ADDR_W(12), .WAIT_STATES(3),
    .RO_MASK(8'h00), .RESET_VAL(32'h5A5A_0000)
  ) u_b (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready_b), .HWDATA(hwdata),
    .HRDATA(hrdata_b), .HREADYOUT(hreadyout_b), .HRESP(hresp_b),
    .reg_o(reg_o_b), .reg_i(reg_i_b), .wr_pulse_o(wr_pulse_b), .rd_pulse_o(rd_pulse_b),
    .dbg_state_o(dbg_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Single NONSEQ transfer; entered and left just after a rising edge.
  task automatic xfer(input bit use_b, input logic [11:0] a, input bit wr,
                      input logic [2:0] sz, input logic [W-1:0] wd,
                      output logic [W-1:0] rd, output logic resp, output int waits,
                      output logic resp_low, output logic [NR-1:0] rdp);
    bit done;
    int guard;
    hsel_a = !use_b; hsel_b = use_b; haddr = a; htrans = 2'b10; hwrite = wr; hsize = sz;
    @(posedge hclk); #1;
    hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd;
    waits = 0; resp_low = 1'b0; done = 1'b0; guard = 0;
    rd = '0; resp = 1'b0; rdp = '0;
    while (!done && guard <= 20) begin
      @(negedge hclk);
      if ((use_b ? hreadyout_b : hreadyout_a) === 1'b1) begin
        done = 1'b1;
        rd   = use_b ? hrdata_b : hrdata_a;
        resp = use_b ? hresp_b : hresp_a;
        rdp  = use_b ? rd_pulse_b : rd_pulse_a;
      end else begin
        waits++;
        resp_low = resp_low | (use_b ? hresp_b : hresp_a);
        guard++;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL xfer_timeout: observed no HREADYOUT after %0d cycles, expected ready", guard);
    end
    @(posedge hclk); #1;
    hwdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0]    rd;
    logic            resp, resp_low;
    int              waits;
    logic [NR-1:0]   rdp;
    logic [NR*W-1:0] snap;

    hresetn = 1'b0; mux_ready = 1'b1;
    hsel_a = 0; hsel_b = 0; haddr = '0; htrans = 2'b00; hwrite = 0; hsize = 3'd2; hwdata = '0;
    reg_i_a = '0; reg_i_a[2*W +: W] = 32'h0000_1234;
    reg_i_b = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_hreadyout", hreadyout_a, 1'b1);
    chk("rst_hresp", hresp_a, 1'b0);
    chk("rst_hrdata", hrdata_a, 32'h0);
    chk("rst_reg_o_a", reg_o_a, '0);
    chk("rst_wr_pulse", wr_pulse_a, 8'h00);
    chk("rst_rd_pulse", rd_pulse_a, 8'h00);
    chk("rst_state", dbg_a, 3'd0);
    chk("rst_reg_o_b3", reg_o_b[3*W +: W], 32'h5A5A_0000);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // Word write then read of register 1
    xfer(0, 12'h004, 1, 3'd2, 32'hDEAD_BEEF, rd, resp, waits, resp_low, rdp);
    chk("wr1_waits", waits, 0);
    chk("wr1_resp", resp, 1'b0);
    chk("wr1_reg1", reg_o_a[1*W +: W], 32'hDEAD_BEEF);
    chk("wr1_pulse", wr_pulse_a, 8'h02);
    @(posedge hclk); #1;
    chk("wr1_pulse_gone", wr_pulse_a, 8'h00);
    xfer(0, 12'h004, 0, 3'd2, '0, rd, resp, waits, resp_low, rdp);
    chk("rd1_data", rd, 32'hDEAD_BEEF);
    chk("rd1_resp", resp, 1'b0);
    chk("rd1_pulse", rdp, 8'h02);
    @(negedge hclk);
    chk("rd1_hrdata_idle", hrdata_a, 32'h0);
    @(posedge hclk); #1;

    // Byte write on lane 2
    xfer(0, 12'h006, 1, 3'd0, 32'h00AA_0000, rd, resp, waits, resp_low, rdp);
    chk("bw_resp", resp, 1'b0);
    chk("bw_reg1", reg_o_a[1*W +: W], 32'hDEAA_BEEF);
    chk("bw_reg0", reg_o_a[0*W +: W], 32'h0);
    chk("bw_reg3", reg_o_a[3*W +: W], 32'h0);

    // Misaligned halfword -> two-cycle ERROR, no change
    snap = reg_o_a;
    xfer(0, 12'h005, 1, 3'd1, 32'hFFFF_FFFF, rd, resp, waits, resp_low, rdp);
    chk("mis_waits", waits, 1);
    chk("mis_resp_low", resp_low, 1'b1);
    chk("mis_resp", resp, 1'b1);
    chk("mis_regs", reg_o_a, snap);

    // Out-of-range write
    xfer(0, 12'h100, 1, 3'd2, 32'h1111_2222, rd, resp, waits, resp_low, rdp);
    chk("oor_waits", waits, 1);
    chk("oor_resp_low", resp_low, 1'b1);
    chk("oor_resp", resp, 1'b1);
    chk("oor_regs", reg_o_a, snap);
    chk("oor_pulse", wr_pulse_a, 8'h00);

    // Read-only register 2
    xfer(0, 12'h008, 0, 3'd2, '0, rd, resp, waits, resp_low, rdp);
    chk("ro_rd_data", rd, 32'h0000_1234);
    chk("ro_rd_resp", resp, 1'b0);
    chk("ro_rd_pulse", rdp, 8'h04);
    xfer(0, 12'h008, 1, 3'd2, 32'h9999_9999, rd, resp, waits, resp_low, rdp);
    chk("ro_wr_waits", waits, 1);
    chk("ro_wr_resp", resp, 1'b1);
    chk("ro_wr_reg2", reg_o_a[2*W +: W], 32'h0);
    chk("ro_wr_pulse", wr_pulse_a, 8'h00);

    // Oversized transfer on a 32-bit bus
    xfer(0, 12'h000, 0, 3'd3, '0, rd, resp, waits, resp_low, rdp);
    chk("size_resp", resp, 1'b1);
    chk("size_waits", waits, 1);

    // Back-to-back write then SEQ read of register 3
    hsel_a = 1; haddr = 12'h00C; htrans = 2'b10; hwrite = 1; hsize = 3'd2;
    @(posedge hclk); #1;
    htrans = 2'b11; hwrite = 0; hwdata = 32'hCAFE_F00D;
    @(negedge hclk);
    chk("b2b_wr_ready", hreadyout_a, 1'b1);
    chk("b2b_wr_resp", hresp_a, 1'b0);
    @(posedge hclk); #1;
    hsel_a = 0; htrans = 2'b00; hwdata = '0;
    @(negedge hclk);
    chk("b2b_rd_data", hrdata_a, 32'hCAFE_F00D);
    chk("b2b_rd_resp", hresp_a, 1'b0);
    chk("b2b_rd_pulse", rd_pulse_a, 8'h08);
    chk("b2b_wr_pulse", wr_pulse_a, 8'h08);
    @(posedge hclk); #1;

    // HREADY low while idle: no accept
    mux_ready = 0; hsel_a = 1; haddr = 12'h000; htrans = 2'b10; hwrite = 1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel_a = 0; htrans = 2'b00; hwrite = 0; hwdata = 32'hFFFF_FFFF; mux_ready = 1;
    @(negedge hclk);
    chk("hold_state", dbg_a, 3'd0);
    chk("hold_ready", hreadyout_a, 1'b1);
    @(posedge hclk); #1;
    hwdata = '0;
    chk("hold_reg0", reg_o_a[0*W +: W], 32'h0);
    chk("hold_pulse", wr_pulse_a, 8'h00);

    // HTRANS=IDLE with HSEL: zero-wait OKAY, nothing happens
    hsel_a = 1; haddr = 12'h004; htrans = 2'b00; hwrite = 1;
    @(posedge hclk); #1;
    hsel_a = 0; hwrite = 0; hwdata = 32'h0;
    @(negedge hclk);
    chk("idle_ready", hreadyout_a, 1'b1);
    chk("idle_resp", hresp_a, 1'b0);
    chk("idle_state", dbg_a, 3'd0);
    @(posedge hclk); #1;
    chk("idle_reg1", reg_o_a[1*W +: W], 32'hDEAA_BEEF);

    // Three wait states on instance B
    xfer(1, 12'h00C, 1, 3'd2, 32'h1122_3344, rd, resp, waits, resp_low, rdp);
    chk("ws_wr_waits", waits, 3);
    chk("ws_wr_resp_low", resp_low, 1'b0);
    chk("ws_wr_resp", resp, 1'b0);
    chk("ws_wr_reg3", reg_o_b[3*W +: W], 32'h1122_3344);
    xfer(1, 12'h00C, 0, 3'd2, '0, rd, resp, waits, resp_low, rdp);
    chk("ws_rd_waits", waits, 3);
    chk("ws_rd_data", rd, 32'h1122_3344);
    chk("ws_rd_resp", resp, 1'b0);

    // Reset in the middle of a wait-state read
    hsel_b = 1; haddr = 12'h00C; htrans = 2'b10; hwrite = 0; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel_b = 0; htrans = 2'b00;
    @(negedge hclk);
    chk("mid_wait_low", hreadyout_b, 1'b0);
    chk("mid_wait_state", dbg_b, 3'd1);
    hresetn = 1'b0;
    #1;
    chk("mid_rst_ready", hreadyout_b, 1'b1);
    chk("mid_rst_resp", hresp_b, 1'b0);
    chk("mid_rst_state", dbg_b, 3'd0);
    chk("mid_rst_reg3_b", reg_o_b[3*W +: W], 32'h5A5A_0000);
    chk("mid_rst_reg3_a", reg_o_a[3*W +: W], 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
